// File: rtl/mpmc_fill_agen.sv
// Cache-fill write address generator: one write strobe and line address per accepted read beat.
// Optional discarded-beat counter is enabled by defining MPMC_FILL_AGEN_OVR_CNT_EN.
module mpmc_fill_agen #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BITS  = 5,
    parameter int BURST_W    = 8,
    parameter int WRAP_BEATS = 4,
    parameter int CLR_TOP    = 2,
    parameter int CH_W       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  base_i,
    input  logic [BURST_W-1:0] len_i,
    input  logic               wrap_i,
    input  logic [CH_W-1:0]    ch_i,
    input  logic               valid_i,
    output logic               we_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [CH_W-1:0]    ch_o,
    output logic [BURST_W-1:0] beat_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [15:0]        ovr_cnt_o
);

    localparam int IDX_W = $clog2(WRAP_BEATS);
    localparam logic [ADDR_W-1:0] TOP_MASK  = {ADDR_W{1'b1}} >> CLR_TOP;
    localparam logic [ADDR_W-1:0] LINE_MASK = TOP_MASK & ({ADDR_W{1'b1}} << LINE_BITS);
    localparam logic [ADDR_W-1:0] BEAT_INC  = {{(ADDR_W-1){1'b0}}, 1'b1} << LINE_BITS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [BURST_W-1:0] beat_r;
    logic [BURST_W-1:0] len_r;
    logic               wrap_r;
    logic [CH_W-1:0]    ch_r;
    logic               busy_r;
    logic               done_r;

    logic               we_s;
    logic               last_s;
    logic [ADDR_W-1:0]  load_addr_s;
    logic [ADDR_W-1:0]  next_addr_s;

    assign we_s        = valid_i & (state_r == ST_FILL);
    assign last_s      = (beat_r == len_r);
    assign load_addr_s = base_i & LINE_MASK;

    // Next beat address: wrap mode only rolls the in-group index, linear mode carries into the upper bits.
    always_comb begin
        next_addr_s = addr_r;
        if (wrap_r) begin
            next_addr_s[LINE_BITS +: IDX_W] = addr_r[LINE_BITS +: IDX_W] + IDX_W'(1'b1);
        end else begin
            next_addr_s = (addr_r + BEAT_INC) & TOP_MASK;
        end
    end

    // Burst FSM; a reload always wins, but a final beat taken in the same cycle still raises done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            addr_r  <= TOP_MASK;
            beat_r  <= {BURST_W{1'b0}};
            len_r   <= {BURST_W{1'b0}};
            wrap_r  <= 1'b0;
            ch_r    <= {CH_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start_i) begin
                done_r  <= we_s & last_s;
                state_r <= ST_FILL;
                addr_r  <= load_addr_s;
                beat_r  <= {BURST_W{1'b0}};
                len_r   <= len_i;
                wrap_r  <= wrap_i;
                ch_r    <= ch_i;
                busy_r  <= 1'b1;
            end else if (we_s) begin
                if (last_s) begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end else begin
                    beat_r <= beat_r + {{(BURST_W-1){1'b0}}, 1'b1};
                    addr_r <= next_addr_s;
                end
            end else begin
                state_r <= state_r;
                addr_r  <= addr_r;
            end
        end
    end

    assign we_o   = we_s;
    assign addr_o = addr_r;
    assign beat_o = beat_r;
    assign ch_o   = ch_r;
    assign busy_o = busy_r;
    assign done_o = done_r;

`ifdef MPMC_FILL_AGEN_OVR_CNT_EN
    logic [15:0] ovr_r;

    // Saturating count of beats that arrive with no fill in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_r <= 16'h0000;
        end else if (valid_i && (state_r == ST_IDLE) && !start_i && (ovr_r != 16'hFFFF)) begin
            ovr_r <= ovr_r + 16'h0001;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign ovr_cnt_o = ovr_r;
`else
    assign ovr_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/mpmc_fill_agen.md
Name: mpmc_fill_agen

Overview:
Parametrised cache-fill (cache write) address generator for the multi-port memory controller read path.
- Loaded once per read burst with a base address, beat count, wrap mode and channel tag.
- Emits a cache write strobe plus line address for every accepted read-data beat.
- Discards any beats beyond the programmed length.
- Supports both linear and critical-word-first (wrapping) fills.

Parameters:
ADDR_W, 32, address width in bits
LINE_BITS, 5, log2 bytes per beat; address advances at bit LINE_BITS, bits below are always 0
BURST_W, 8, width of the beat-length field and beat counter
WRAP_BEATS, 4, wrap group size in beats for wrap mode; must be a power of 2 and at least 2
CLR_TOP, 2, number of address MSBs forced to 0
CH_W, 3, channel tag width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous reset, active-low
start_i  in  1  one-cycle load pulse
base_i  in  ADDR_W  burst start byte address
len_i  in  BURST_W  beat count minus one
wrap_i  in  1  1 = wrap within the WRAP_BEATS group; 0 = linear
ch_i  in  CH_W  requesting channel tag
valid_i  in  1  read-data beat valid from the memory interface
we_o  out  1  cache write enable
addr_o  out  ADDR_W  cache write address for the current beat
ch_o  out  CH_W  latched channel tag
beat_o  out  BURST_W  index of the current beat
busy_o  out  1  fill in progress
done_o  out  1  one-cycle pulse after the last beat
ovr_cnt_o  out  16  count of discarded beats (see Optional Feature)

Behaviour:
- Reset (rst low, asynchronous) puts every output in a defined state:
  - addr_o = {CLR_TOP zeros, all ones}.
  - beat_o, ch_o, done_o, busy_o, ovr_cnt_o = 0.
  - State = IDLE.
- States: IDLE, FILL.
- start_i in any state (reload):
  - Latch len_i, wrap_i, ch_i; beat_o <= 0; busy_o <= 1; state <= FILL.
  - Linear: addr_o <= base_i with bits [LINE_BITS-1:0] = 0.
  - Wrap: same load; the beat-index field [LINE_BITS +: log2(WRAP_BEATS)] keeps base_i's value, so the critical beat is first.
- we_o is combinational: valid_i & (state==FILL). Zero latency; addr_o, beat_o and ch_o are valid in the same cycle as we_o.
- Accepted beat (we_o=1), next edge:
  - If beat_o != len: beat_o increments and the address advances.
    - Linear: addr_o[ADDR_W-1:LINE_BITS] + 1, carrying freely.
    - Wrap: only the index field increments, modulo WRAP_BEATS; upper bits hold.
  - If beat_o == len: state <= IDLE, busy_o <= 0, done_o <= 1 for one cycle; addr_o and beat_o hold.
- valid_i in IDLE: we_o=0 and the beat is discarded; addr_o holds.
- start_i and final valid_i in the same cycle: the final beat is written with the old address (we_o=1); done_o pulses next cycle; the new burst load takes priority for all registers.
- start_i and a non-final valid_i in FILL: the beat is written; the reload wins and the old burst is abandoned with no done_o.
- len_i=0: exactly one beat is written.
- The top CLR_TOP bits of addr_o are 0 at all times, including after carry out of the address.
- Address wrap-around past the cleared top bits is silent; no flag is raised.
- Reset asserted mid-burst: immediate return to reset values; no done_o.

Optional Feature:
Macro: MPMC_FILL_AGEN_OVR_CNT_EN.
- Defined:
  - ovr_cnt_o increments, saturating at 16'hFFFF, on each valid_i with state==IDLE and start_i=0.
  - It clears only on reset.
- Undefined:
  - ovr_cnt_o is tied to 0 and no counter logic is present.
  - All other behaviour is identical.

Test Plan:
- Linear fill. Reset, then start_i with base_i=32'h0000_1234, len_i=3, wrap_i=0, then four valid_i beats.
  -> we_o addresses 1220, 1240, 1260, 1280; beat_o 0..3; done_o one cycle after the 4th beat; busy_o drops.
- Wrap fill. base_i=32'h0000_1060, len_i=3, wrap_i=1 (WRAP_BEATS=4).
  -> addresses 1060, 1000, 1020, 1040; upper bits never change.
- Overrun. After the test-1 burst, apply two extra valid_i.
  -> we_o=0 and addr_o holds 1280; ovr_cnt_o=2 with the macro defined, 0 without.
- Simultaneous start/last beat. start_i (base 2000, len 1) in the same cycle as the final beat of a prior burst.
  -> old last address written; done_o pulses; next beats at 2000, 2020.
- Top-bit clear and reset. base_i=32'hFFFF_FFE0, len_i=1.
  -> first address 3FFF_FFE0; next address 0000_0000 (top 2 bits clear, carry dropped).
  - Then assert rst mid-burst -> addr_o=3FFF_FFFF, busy_o=0, no done_o.
